// File: rtl/axi4_mem_pkg.sv
// Shared types, limits and helpers for the pipelined AXI4 backing memory.
package axi4_mem_pkg;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } mem_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH         = DEFAULT_DATA_WIDTH / 8;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 4;

  // Widest word strb_merge handles; narrower callers zero-extend and truncate.
  localparam int unsigned MERGE_MAX_WIDTH = 512;
  localparam int unsigned MERGE_MAX_STRB  = MERGE_MAX_WIDTH / 8;

  // Replace each byte of old_word whose strobe bit is set with the matching byte of new_word.
  function automatic logic [MERGE_MAX_WIDTH-1:0] strb_merge(
    input logic [MERGE_MAX_WIDTH-1:0] old_word,
    input logic [MERGE_MAX_WIDTH-1:0] new_word,
    input logic [MERGE_MAX_STRB-1:0]  strb
  );
    logic [MERGE_MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MERGE_MAX_STRB; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_mem_rd_pipe.sv
// Valid/data shift register adding DEPTH cycles to the read path; data only advances with valid.
module axi4_mem_rd_pipe
  import axi4_mem_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (DEPTH < RD_LATENCY_MIN || DEPTH > RD_LATENCY_MAX) begin : g_chk_depth
    $error("axi4_mem_rd_pipe: DEPTH out of range");
  end

  logic [DEPTH-1:0]      v_q;
  logic [DATA_WIDTH-1:0] d_q    [DEPTH];
  logic [DEPTH-1:0]      v_prev;
  logic [DATA_WIDTH-1:0] d_prev [DEPTH];

  // Feed for each stage: the pipe input for stage 0, the previous stage otherwise.
  always_comb begin
    v_prev    = '0;
    v_prev[0] = in_valid;
    d_prev[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      v_prev[i] = v_q[i-1];
      d_prev[i] = d_q[i-1];
    end
  end

  // Shift valid every cycle; capture data only on valid so the last stage holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        v_q[i] <= v_prev[i];
        if (v_prev[i]) begin
          d_q[i] <= d_prev[i];
        end
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: rtl/axi4_pipelined_memory.sv
// Dual-port (1W + 1R) byte-strobed backing memory with self-clearing init and pipelined reads.
module axi4_pipelined_memory
  import axi4_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned WRITE_FIRST  = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    mem_ready,
  output logic                    addr_err
);

  localparam int unsigned IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(MEMORY_DEPTH - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("axi4_pipelined_memory: DATA_WIDTH must be a multiple of 8");
  end
  if (DATA_WIDTH > MERGE_MAX_WIDTH) begin : g_chk_dw_max
    $error("axi4_pipelined_memory: DATA_WIDTH exceeds strb_merge width");
  end
  if (MEMORY_DEPTH > (64'd1 << ADDR_WIDTH)) begin : g_chk_depth
    $error("axi4_pipelined_memory: MEMORY_DEPTH exceeds address space");
  end
  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_chk_lat
    $error("axi4_pipelined_memory: RD_LATENCY out of range");
  end

  mem_state_e            state;
  logic [IDX_W-1:0]      init_cnt;
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic                  wr_acc, rd_acc;
  logic                  wr_in_range, rd_in_range;
  logic                  collide;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_word;

  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic                  err_q;

  // Request qualification, address decode and the strobe-merged word for the write port.
  always_comb begin
    wr_acc      = ARESETn & mem_ready & wr_en;
    rd_acc      = ARESETn & mem_ready & rd_en;
    wr_in_range = {1'b0, wr_addr} < DEPTH_A;
    rd_in_range = {1'b0, rd_addr} < DEPTH_A;
    wr_idx      = wr_addr[IDX_W-1:0];
    rd_idx      = rd_addr[IDX_W-1:0];
    collide     = wr_acc & wr_in_range & rd_acc & rd_in_range & (wr_addr == rd_addr);
    wr_word     = DATA_WIDTH'(strb_merge(MERGE_MAX_WIDTH'(mem[wr_idx]),
                                         MERGE_MAX_WIDTH'(wr_data),
                                         MERGE_MAX_STRB'(wr_strb)));
  end

  // Init/idle sequencer: clear every word once after reset, then stay ready until the next reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      mem_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == LAST_IDX) begin
            state     <= ST_IDLE;
            mem_ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_IDLE: mem_ready <= 1'b1;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Storage write port: zero-fill during init, otherwise accepted in-range writes.
  always_ff @(posedge ACLK) begin
    if (ARESETn && state == ST_INIT) begin
      mem[init_cnt] <= '0;
    end else if (wr_acc && wr_in_range) begin
      mem[wr_idx] <= wr_word;
    end
  end

  // Read capture on the accept edge, so old-data collisions see the pre-write word;
  // the write-first bypass uses the merged word instead. Also stages the address error.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_vld_q  <= 1'b0;
      rd_word_q <= '0;
      err_q     <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) begin
        if (!rd_in_range) begin
          rd_word_q <= '0;
        end else if (WRITE_FIRST != 0 && collide) begin
          rd_word_q <= wr_word;
        end else begin
          rd_word_q <= mem[rd_idx];
        end
      end
      err_q    <= (wr_acc & ~wr_in_range) | (rd_acc & ~rd_in_range);
      addr_err <= err_q;
    end
  end

  axi4_mem_rd_pipe #(
    .DEPTH      (RD_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .in_valid  (rd_vld_q),
    .in_data   (rd_word_q),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule
